riscv_uart_rx: RTL and testbench
================================

# riscv_uart_rx

Serial-to-parallel UART receive peripheral: the upstream counterpart of the existing UART TX peripheral, feeding received bytes to the core's memory-mapped I/O path. It synchronises the RX pin, detects start bits, samples 8N1/8E1/8O1 frames at mid-bit, checks parity and stop bit, and buffers good bytes in a show-ahead FIFO that the core pops one byte at a time. Instantiated in the top level beside the TX peripheral, on the same clock and reset.

## Interface
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥2
- BAUD_DIVISOR, 20'd6945, clock cycles per bit (logic [19:0]); ≥4
- PAR_EN, 1'b1, parity bit present in frame
- PAR_TYPE, 1'b0, 0 = even, 1 = odd
- i_uart_clk  in  1  core clock; all logic on rising edge
- i_uart_rst_n  in  1  asynchronous active-low reset
- i_uart_rx_sdata  in  1  serial RX pin, asynchronous, idle high
- i_uart_rx_pop  in  1  core consumes head byte this cycle
- i_uart_rx_err_clr  in  1  clears sticky error flags
- o_uart_rx_pdata  out  8  FIFO head byte; valid when o_uart_rx_valid
- o_uart_rx_valid  out  1  FIFO not empty
- o_uart_rx_fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
- o_uart_rx_busy  out  1  FSM not in IDLE
- o_uart_rx_par_err  out  1  sticky parity error
- o_uart_rx_frame_err  out  1  sticky stop-bit error
- o_uart_rx_overrun  out  1  sticky byte-dropped-on-full

## Operation
- Reset: all outputs 0, pdata 8'h00, FIFO empty, FSM IDLE, synchroniser flops reset to 1.
- RX pin passes through a 2-flop synchroniser; all logic sees synced value `rx_s`.
- FSM states IDLE, START, DATA, PARITY, STOP; one bit counter (0..BAUD_DIVISOR-1) and bit index (0..7).
- IDLE: `rx_s`==0 → START, counter cleared.
- START: at counter == BAUD_DIVISOR/2 − 1 (integer division) sample: 0 → DATA, counter cleared; 1 → IDLE (glitch rejected, no flag).
- DATA: sample each time counter == BAUD_DIVISOR−1; shift into byte LSB first; after bit 7 → PARITY if PAR_EN else STOP.
- PARITY: sample once; error if XOR(data, parity bit) ≠ PAR_TYPE. → STOP.
- STOP: sample once; 0 = framing error. Always → IDLE on that cycle (no wait for line high; a line still low restarts START next cycle).
- Frame accepted iff stop==1 and no parity error: push byte to FIFO on the STOP sample edge. Bad frames discarded, corresponding sticky flag set.
- Push while full and no same-cycle pop: byte dropped, overrun set, FIFO unchanged.
- Pop with o_uart_rx_valid==0 ignored. Push and pop same cycle: both take effect (also when full, so no overrun).
- Sticky flags clear on i_uart_rx_err_clr; a set event in the same cycle wins.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Taking START entry as cycle 0: start sample cycle BAUD_DIVISOR/2 − 1; data bit k sample cycle BAUD_DIVISOR/2 − 1 + (k+1)·BAUD_DIVISOR; stop sample at +9·BAUD_DIVISOR (PAR_EN=0) or +10·BAUD_DIVISOR (PAR_EN=1).
- START entry is 3 cycles after the pin falling edge (2 sync + 1 IDLE detect).
- o_uart_rx_valid, pdata, full, and error flags update the cycle after the push/pop/error edge (all registered).
- Pop takes effect on the edge it is asserted; next head visible the following cycle.
- o_uart_rx_busy high from START entry through the STOP sample cycle.

## Configuration
- UART_RX_ERR_FLAGS_EN defined: sticky par/frame/overrun flags and clear input active as above.
- Undefined: the three flag outputs are tied 0, i_uart_rx_err_clr is ignored; bad frames still discarded and overrun bytes still dropped.

## Structure
- Package uart_rx_pkg: FSM state enum (uart_rx_state_e), data width constant (8), parity-type constants.
- Sub-module riscv_uart_rx_fifo: synchronous show-ahead FIFO (push, pop, data, empty, full) parameterised on FIFO_DEPTH and width; FSM, synchroniser and flags in the top of the block.

## Test plan
- PAR_EN=1 even, BAUD_DIVISOR=16: send 8'hA5 with parity 0 → valid after stop sample, pdata 8'hA5, no flags; pop → valid 0.
- Send 8'h3C with flipped parity bit → FIFO stays empty, par_err 1; err_clr pulse → par_err 0.
- Send 8'h81 with stop bit 0 → no push, frame_err 1; following good byte 8'h42 still received.
- 4-cycle low glitch on idle line → returns to IDLE, no push, no flags.
- FIFO_DEPTH=4: send 5 bytes 8'h01..8'h05 without pop → full after 4th, overrun 1, pops return 01,02,03,04.
- Full FIFO, pop asserted on the push edge of a 6th byte 8'h06 → no overrun, FIFO order preserved with 8'h06 at tail; assert reset mid-frame → all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive peripheral: frame data width,
// receiver FSM state encoding and parity-type encodings.
package uart_rx_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } uart_rx_par_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_e;

endpackage

// File: rtl/riscv_uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes.
// The head entry is always presented on o_data.
// A push is accepted when the FIFO is not full, or when a pop is accepted in
// the same cycle. A pop is ignored while the FIFO is empty.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data, i_pop,
//        o_data (head), o_empty, o_full.
module riscv_uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == CW'(DEPTH));
   assign o_data  = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = i_pop & ~o_empty;
      // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
      push_ok  = i_push & (~o_full | pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = i_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/riscv_uart_rx.sv
// UART receive peripheral (8N1 / 8E1 / 8O1).
// The RX pin is synchronised, frames are sampled at mid-bit, parity and stop
// are checked, and good bytes are queued in a show-ahead FIFO for the core.
// Optional macro UART_RX_ERR_FLAGS_EN enables the sticky par/frame/overrun
// flags and i_uart_rx_err_clr; without it the flags read 0.
// Ports: i_uart_clk, i_uart_rst_n (async active-low), i_uart_rx_sdata (pin),
//        i_uart_rx_pop, i_uart_rx_err_clr, o_uart_rx_pdata (FIFO head),
//        o_uart_rx_valid, o_uart_rx_fifo_full, o_uart_rx_busy,
//        o_uart_rx_par_err, o_uart_rx_frame_err, o_uart_rx_overrun.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for rx_s low
// ST_START  | timing to mid start bit, rejects glitches
// ST_DATA   | sampling 8 data bits LSB first
// ST_PARITY | sampling parity bit
// ST_STOP   | sampling stop bit, push or discard frame
module riscv_uart_rx
   import uart_rx_pkg::*;
#(
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [19:0] BAUD_DIVISOR = 20'd6945,
   parameter logic        PAR_EN       = 1'b1,
   parameter logic        PAR_TYPE     = PAR_EVEN
) (
   input  logic                   i_uart_clk,
   input  logic                   i_uart_rst_n,
   input  logic                   i_uart_rx_sdata,
   input  logic                   i_uart_rx_pop,
   input  logic                   i_uart_rx_err_clr,
   output logic [UART_DATA_W-1:0] o_uart_rx_pdata,
   output logic                   o_uart_rx_valid,
   output logic                   o_uart_rx_fifo_full,
   output logic                   o_uart_rx_busy,
   output logic                   o_uart_rx_par_err,
   output logic                   o_uart_rx_frame_err,
   output logic                   o_uart_rx_overrun
);

   localparam logic [19:0] HALF_M1 = (BAUD_DIVISOR >> 1) - 20'd1;
   localparam logic [19:0] FULL_M1 = BAUD_DIVISOR - 20'd1;

   logic [1:0]             sync_q, sync_d;
   logic                   rx_s;
   uart_rx_state_e         state_q, state_d;
   logic [19:0]            cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   par_bad_q, par_bad_d;

   logic sample, par_mismatch, push, par_set, frame_set, overrun_set;
   logic fifo_empty, fifo_full;

   assign sync_d = {sync_q[0], i_uart_rx_sdata};
   assign rx_s   = sync_q[1];

   // State register plus the datapath flops it steers.
   always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
      if (!i_uart_rst_n) begin
         sync_q    <= 2'b11;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
      end
   end

   assign sample       = (cnt_q == FULL_M1);
   assign par_mismatch = ((^{shift_q, rx_s}) != PAR_TYPE);

   // Next state. The counter free-runs and is cleared on every sample point.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 20'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (sample) begin
               cnt_d     = '0;
               par_bad_d = par_mismatch;
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            // Returns to IDLE at once; a line still low restarts START.
            if (sample) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs of the FSM: FIFO push and error events.
   always_comb begin
      push        = (state_q == ST_STOP) && sample && rx_s && !par_bad_q;
      par_set     = (state_q == ST_PARITY) && sample && par_mismatch;
      frame_set   = (state_q == ST_STOP) && sample && !rx_s;
      // A pop on a full FIFO is always accepted, so it frees the slot.
      overrun_set = push && fifo_full && !i_uart_rx_pop;
      o_uart_rx_busy = (state_q != ST_IDLE);
   end

   riscv_uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .i_clk   (i_uart_clk),
      .i_rst_n (i_uart_rst_n),
      .i_push  (push),
      .i_data  (shift_q),
      .i_pop   (i_uart_rx_pop),
      .o_data  (o_uart_rx_pdata),
      .o_empty (fifo_empty),
      .o_full  (fifo_full)
   );

   assign o_uart_rx_valid     = ~fifo_empty;
   assign o_uart_rx_fifo_full = fifo_full;

`ifdef UART_RX_ERR_FLAGS_EN
   logic par_err_q, par_err_d;
   logic frame_err_q, frame_err_d;
   logic overrun_q, overrun_d;

   // A set event in the same cycle as the clear wins.
   always_comb begin
      par_err_d   = (par_err_q   & ~i_uart_rx_err_clr) | par_set;
      frame_err_d = (frame_err_q & ~i_uart_rx_err_clr) | frame_set;
      overrun_d   = (overrun_q   & ~i_uart_rx_err_clr) | overrun_set;
   end

   always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
      if (!i_uart_rst_n) begin
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_uart_rx_par_err   = par_err_q;
   assign o_uart_rx_frame_err = frame_err_q;
   assign o_uart_rx_overrun   = overrun_q;
`else
   logic unused_flag_sigs;
   assign unused_flag_sigs    = ^{i_uart_rx_err_clr, par_set, frame_set, overrun_set};
   assign o_uart_rx_par_err   = 1'b0;
   assign o_uart_rx_frame_err = 1'b0;
   assign o_uart_rx_overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_uart_rx.sv
// Bench for riscv_uart_rx: BAUD_DIVISOR=16, FIFO_DEPTH=4, even parity.
// Stimulus pushes the bytes it expects to be received into a queue; a monitor
// compares the FIFO head against that queue whenever the bench pops.
module tb_riscv_uart_rx;

   localparam int   B        = 16;
   localparam logic PAR_T    = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
   localparam logic FE = 1'b1;
`else
   localparam logic FE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sdata = 1'b1;
   logic       pop = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] pdata;
   logic       valid, full, busy, par_err, frame_err, overrun;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q [$];

   riscv_uart_rx #(
      .FIFO_DEPTH   (4),
      .BAUD_DIVISOR (20'd16),
      .PAR_EN       (1'b1),
      .PAR_TYPE     (1'b0)
   ) dut (
      .i_uart_clk          (clk),
      .i_uart_rst_n        (rst_n),
      .i_uart_rx_sdata     (sdata),
      .i_uart_rx_pop       (pop),
      .i_uart_rx_err_clr   (err_clr),
      .o_uart_rx_pdata     (pdata),
      .o_uart_rx_valid     (valid),
      .o_uart_rx_fifo_full (full),
      .o_uart_rx_busy      (busy),
      .o_uart_rx_par_err   (par_err),
      .o_uart_rx_frame_err (frame_err),
      .o_uart_rx_overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts right after a posedge; start bit is on the pin from this instant.
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_v, input logic good);
      if (good) exp_q.push_back(d);
      sdata = 1'b0;
      tick(B);
      for (int i = 0; i < 8; i++) begin
         sdata = d[i];
         tick(B);
      end
      sdata = (^d) ^ PAR_T ^ par_flip;
      tick(B);
      sdata = stop_v;
      tick(B);
      sdata = 1'b1;
      tick(3 * B);
   endtask

   task automatic do_pop();
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
      tick(1);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 400 && !valid; i++) tick(1);
      check(name, valid, 1);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && pop && valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%0h expected=none", pdata);
         end else begin
            check("pop_data", pdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200_000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      tick(5);
      rst_n = 1'b1;
      tick(2);
      check("rst_valid", valid, 0);
      check("rst_pdata", pdata, 8'h00);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {par_err, frame_err, overrun}, 3'b000);

      // Good byte.
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      wait_valid("a5_valid");
      check("a5_flags", {par_err, frame_err, overrun}, 3'b000);
      do_pop();
      check("a5_valid_after_pop", valid, 0);
      do_pop();
      check("empty_pop_ignored", {valid, full}, 2'b00);

      // Parity error.
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      check("par_no_push", valid, 0);
      check("par_err_set", {par_err, frame_err}, {FE, 1'b0});
      pulse_clr();
      check("par_err_clr", par_err, 0);

      // Framing error, then a good byte.
      send_frame(8'h81, 1'b0, 1'b0, 1'b0);
      tick(B);
      check("frame_no_push", valid, 0);
      check("frame_err_set", {par_err, frame_err}, {1'b0, FE});
      check("frame_idle", busy, 0);
      pulse_clr();
      check("frame_err_clr", frame_err, 0);
      send_frame(8'h42, 1'b0, 1'b1, 1'b1);
      wait_valid("b42_valid");
      do_pop();

      // Start-bit glitch.
      sdata = 1'b0;
      tick(4);
      sdata = 1'b1;
      tick(1);
      check("glitch_busy", busy, 1);
      tick(20);
      check("glitch_idle", busy, 0);
      check("glitch_no_push", valid, 0);
      check("glitch_flags", {par_err, frame_err, overrun}, 3'b000);

      // Overrun: fifth byte dropped.
      for (int i = 1; i <= 5; i++)
         send_frame(8'(i), 1'b0, 1'b1, i <= 4);
      check("ovr_full", full, 1);
      check("ovr_flag", overrun, FE);
      for (int i = 0; i < 4; i++) do_pop();
      check("ovr_drained", {valid, full}, 2'b00);
      pulse_clr();
      check("ovr_clr", overrun, 0);

      // Full FIFO with a pop on the push edge of 8'h06.
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1);
      check("fill_full", full, 1);
      fork
         send_frame(8'h06, 1'b0, 1'b1, 1'b1);
         begin
            repeat (170) @(posedge clk);
            #1 pop = 1'b1;
            @(posedge clk);
            #1 pop = 1'b0;
         end
      join
      check("poppush_full", full, 1);
      check("poppush_no_ovr", overrun, 0);
      for (int i = 0; i < 4; i++) do_pop();
      check("poppush_drained", valid, 0);

      // Reset in the middle of a frame with state to clear.
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      sdata = 1'b0;
      tick(40);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      sdata = 1'b1;
      exp_q.delete();
      tick(2);
      check("mrst_outputs", {valid, full, busy, par_err, frame_err, overrun}, 6'b0);
      check("mrst_pdata", pdata, 8'h00);
      rst_n = 1'b1;
      tick(20);
      send_frame(8'h99, 1'b0, 1'b1, 1'b1);
      wait_valid("b99_valid");
      do_pop();
      check("end_empty", valid, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
